// File: rtl/sysarr_mac_pipe_pkg.sv
// sys_arr_pkg: shared definitions for the systolic-array MAC processing element.
//   DEF_DW / DEF_AW       default operand and accumulator widths
//   DEF_MUL_LEN / ADD_LEN default multiply / add pipeline depths
//   LAT                   issue-to-output latency for the default depths
//   ACC_MAX / ACC_MIN     signed clamp limits for the default accumulator width
//   mac_mode_t            per-operation mode bits that travel down the pipe
package sys_arr_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 32;
  localparam int DEF_MUL_LEN = 2;
  localparam int DEF_ADD_LEN = 1;
  localparam int LAT         = DEF_MUL_LEN + DEF_ADD_LEN;

  localparam logic [DEF_AW-1:0] ACC_MAX = {1'b0, {(DEF_AW-1){1'b1}}};
  localparam logic [DEF_AW-1:0] ACC_MIN = {1'b1, {(DEF_AW-1){1'b0}}};

  typedef struct packed {
    logic signed_en;
    logic sat_en;
  } mac_mode_t;

endpackage

// File: rtl/sysarr_mac_pipe_if.sv
// sysarr_mac_pipe_if: operand, weight, partial-sum and status signals of one
// MAC cell.
//   slave  : the MAC cell (consumes operands, produces partial sum / status)
//   master : whatever drives the cell (neighbours, controller, testbench)
// Handshake: in_valid is a one-cycle issue strobe with no ready; out_valid is a
// one-cycle result strobe and the receiver must accept it (no back-pressure).
interface sysarr_mac_pipe_if
  import sys_arr_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  logic [DW-1:0] in_value;
  logic          in_valid;
  logic          shift;
  logic [DW-1:0] in_pass;
  logic [DW-1:0] weight_in;
  logic          weight_load;
  logic          weight_swap;
  logic [AW-1:0] in_accumulate;
  logic          signed_en;
  logic          sat_en;
  logic          ovf_clr;
  logic [AW-1:0] out_accumulate;
  logic          out_valid;
  logic          ovf_flag;

  modport slave (
    input  in_value, in_valid, shift, weight_in, weight_load, weight_swap,
           in_accumulate, signed_en, sat_en, ovf_clr,
    output in_pass, out_accumulate, out_valid, ovf_flag
  );

  modport master (
    output in_value, in_valid, shift, weight_in, weight_load, weight_swap,
           in_accumulate, signed_en, sat_en, ovf_clr,
    input  in_pass, out_accumulate, out_valid, ovf_flag
  );
endinterface

// File: rtl/sysarr_pipe_delay.sv
// sysarr_pipe_delay: DEPTH-stage register delay line with a valid bit.
//   clk, rst (async, active-high)
//   in_valid / in_data   : entry into the first stage
//   out_valid / out_data : last stage
// The valid bit shifts every cycle so bubbles are preserved; a stage only
// loads data when the incoming valid is set, so the last stage keeps the most
// recent valid value during bubbles.
module sysarr_pipe_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [W-1:0] data_q [DEPTH];
  logic         vld_q  [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/sysarr_mac_pipe.sv
// sysarr_mac_pipe: pipelined integer MAC processing element.
//   clk, RST (async, active-high)
//   bus (slave): operand pass-through, double-buffered weight, issue strobe,
//                partial sum in/out, signed/saturate mode, sticky overflow.
// Pipeline: issue register (stage 0) -> MUL_LEN product stages -> ADD_LEN sum
// stages, so a result appears MUL_LEN+ADD_LEN edges after its issuing edge.
module sysarr_mac_pipe
  import sys_arr_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MUL_LEN = DEF_MUL_LEN,
  parameter int ADD_LEN = DEF_ADD_LEN
) (
  input  logic              clk,
  input  logic              RST,
  sysarr_mac_pipe_if.slave  bus
);
  localparam int MW = 1 + AW + (AW + 1);   // {sat_en, accumulate, product}
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  logic [DW-1:0] pass_q, shadow_w, active_w;
  logic          s0_valid;
  logic [DW-1:0] s0_value, s0_weight;
  logic [AW-1:0] s0_acc;
  mac_mode_t     s0_mode;
  logic          ovf_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pass_q    <= '0;
      shadow_w  <= '0;
      active_w  <= '0;
      s0_valid  <= 1'b0;
      s0_value  <= '0;
      s0_weight <= '0;
      s0_acc    <= '0;
      s0_mode   <= '0;
    end else begin
      if (bus.shift)       pass_q   <= bus.in_value;
      if (bus.weight_load) shadow_w <= bus.weight_in;
      // Non-blocking: a coincident load leaves the old shadow in active.
      if (bus.weight_swap) active_w <= shadow_w;
      s0_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s0_value  <= bus.in_value;
        s0_weight <= active_w;     // pre-swap weight on the issue edge
        s0_acc    <= bus.in_accumulate;
        s0_mode   <= '{signed_en: bus.signed_en, sat_en: bus.sat_en};
      end
    end
  end

  assign bus.in_pass = pass_q;

  // Multiply: both products are formed at 2*DW bits; the mode picks one and
  // its extension to AW+1 bits.
  logic [2*DW-1:0] prod_s, prod_u;
  logic [AW:0]     prod_ext;

  always_comb begin
    prod_u = {{DW{1'b0}}, s0_value} * {{DW{1'b0}}, s0_weight};
    prod_s = $signed({{DW{s0_value[DW-1]}}, s0_value}) *
             $signed({{DW{s0_weight[DW-1]}}, s0_weight});
    if (s0_mode.signed_en) prod_ext = {{(AW+1-2*DW){prod_s[2*DW-1]}}, prod_s};
    else                   prod_ext = {{(AW+1-2*DW){1'b0}}, prod_u};
  end

  logic          m_valid;
  logic [MW-1:0] m_data;

  sysarr_pipe_delay #(.W(MW), .DEPTH(MUL_LEN)) u_mul_pipe (
    .clk       (clk),
    .rst       (RST),
    .in_valid  (s0_valid),
    .in_data   ({s0_mode.sat_en, s0_acc, prod_ext}),
    .out_valid (m_valid),
    .out_data  (m_data)
  );

  logic          m_sat;
  logic [AW-1:0] m_acc;
  logic [AW:0]   m_prod, sum;
  logic          sum_ovf;
  logic [AW-1:0] sum_res;

  always_comb begin
    m_sat   = m_data[MW-1];
    m_acc   = m_data[MW-2 -: AW];
    m_prod  = m_data[AW:0];
    sum     = m_prod + {m_acc[AW-1], m_acc};
    // Outside the signed AW range exactly when the two top bits differ.
    sum_ovf = sum[AW] ^ sum[AW-1];
    sum_res = sum[AW-1:0];
    if (sum_ovf && m_sat) sum_res = sum[AW] ? SAT_MIN : SAT_MAX;
  end

  logic          a_valid;
  logic [AW:0]   a_data;   // {overflow, result}

  sysarr_pipe_delay #(.W(AW+1), .DEPTH(ADD_LEN)) u_add_pipe (
    .clk       (clk),
    .rst       (RST),
    .in_valid  (m_valid),
    .in_data   ({sum_ovf, sum_res}),
    .out_valid (a_valid),
    .out_data  (a_data)
  );

  assign bus.out_valid      = a_valid;
  assign bus.out_accumulate = a_data[AW-1:0];

  // The flag shows an overflowing result in the same cycle it is presented;
  // ovf_q remembers it afterwards, and a new overflow beats ovf_clr.
  logic new_ovf;
  assign new_ovf = a_valid & a_data[AW];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= new_ovf | (ovf_q & ~bus.ovf_clr);
  end

  assign bus.ovf_flag = ovf_q | new_ovf;
endmodule

// File: tb/tb_sysarr_mac_pipe.sv
// tb_sysarr_mac_pipe: directed plus random stimulus against an arithmetic
// reference model of the MAC cell; checks every cycle.
module tb_sysarr_mac_pipe;
  import sys_arr_pkg::*;

  localparam int DW = DEF_DW;
  localparam int AW = DEF_AW;

  typedef struct {
    int unsigned   due;
    logic [AW-1:0] val;
    logic          ovf;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  sysarr_mac_pipe_if #(.DW(DW), .AW(AW)) bus ();

  sysarr_mac_pipe #(.DW(DW), .AW(AW), .MUL_LEN(DEF_MUL_LEN), .ADD_LEN(DEF_ADD_LEN)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- scoreboard / model state ----------------
  exp_t          exp_q[$];
  int unsigned   cyc;
  int            checks, errors;
  logic [DW-1:0] shadow_m, active_m, pass_m;
  logic [AW-1:0] last_m;
  logic          sticky_m, pres_ovf;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [DW-1:0] v, logic [DW-1:0] w,
                                 logic [AW-1:0] acc, logic sgn, logic sat);
    exp_t   r;
    longint a, b, s, sum, mx, mn;
    mx = (longint'(1) << (AW-1)) - 1;
    mn = -(longint'(1) << (AW-1));
    a = longint'(v);
    b = longint'(w);
    if (sgn && v[DW-1]) a = a - (longint'(1) << DW);
    if (sgn && w[DW-1]) b = b - (longint'(1) << DW);
    s = longint'(acc);
    if (acc[AW-1]) s = s - (longint'(1) << AW);
    sum   = a * b + s;
    r.ovf = (sum > mx) || (sum < mn);
    if (r.ovf && sat) r.val = (sum > mx) ? ACC_MAX : ACC_MIN;
    else              r.val = sum[AW-1:0];
    r.due = 0;
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    shadow_m = '0; active_m = '0; pass_m = '0;
    last_m = '0; sticky_m = 1'b0; pres_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    exp_t e;
    logic pres;
    pres = 1'b0;
    pres_ovf = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      pres = 1'b1;
      last_m = e.val;
      pres_ovf = e.ovf;
    end
    chk("out_valid", bus.out_valid, pres);
    chk("out_accumulate", bus.out_accumulate, last_m);
    chk("ovf_flag", bus.ovf_flag, sticky_m || pres_ovf);
    chk("in_pass", bus.in_pass, pass_m);
  endtask

  // ---------------- driver ----------------
  // Inputs are already driven; update the model for the coming edge, clock, check.
  task automatic step();
    exp_t e;
    if (!RST) begin
      if (bus.in_valid) begin
        e = model(bus.in_value, active_m, bus.in_accumulate, bus.signed_en, bus.sat_en);
        e.due = cyc + 1 + LAT;
        exp_q.push_back(e);
      end
      sticky_m = pres_ovf || (sticky_m && !bus.ovf_clr);
      if (bus.weight_swap) active_m = shadow_m;
      if (bus.weight_load) shadow_m = bus.weight_in;
      if (bus.shift) pass_m = bus.in_value;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.in_value = '0; bus.in_valid = 1'b0; bus.shift = 1'b0;
    bus.weight_in = '0; bus.weight_load = 1'b0; bus.weight_swap = 1'b0;
    bus.in_accumulate = '0; bus.signed_en = 1'b0; bus.sat_en = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic load_weight(logic [DW-1:0] w);
    bus.weight_load = 1'b1; bus.weight_in = w;
    step();
    bus.weight_load = 1'b0; bus.weight_swap = 1'b1;
    step();
    bus.weight_swap = 1'b0;
  endtask

  task automatic issue(logic [DW-1:0] v, logic [AW-1:0] acc, logic sgn, logic sat);
    bus.in_valid = 1'b1; bus.in_value = v; bus.in_accumulate = acc;
    bus.signed_en = sgn; bus.sat_en = sat;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(string tag, logic [AW-1:0] val);
    repeat (LAT - 1) step();
    chk({tag, "_early"}, bus.out_valid, 1'b0);
    step();
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_value"}, bus.out_accumulate, val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] thr_exp [4];
    int unsigned   i0;
    checks = 0; errors = 0; cyc = 0;
    thr_exp[0] = 3; thr_exp[1] = 6; thr_exp[2] = 9; thr_exp[3] = 28;
    idle_inputs();
    model_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    chk("reset_acc", bus.out_accumulate, 0);
    chk("reset_ovf", bus.ovf_flag, 0);

    // Unsigned basic
    load_weight(8'd200);
    issue(8'd250, 32'd1000, 1'b0, 1'b0);
    wait_result("unsigned", 32'd51000);
    step();
    chk("unsigned_single", bus.out_valid, 1'b0);

    // Signed mode: -1 * -128 - 5 = 123
    load_weight(8'hFF);
    issue(8'h80, -32'sd5, 1'b1, 1'b0);
    wait_result("signed", 32'd123);

    // Back-to-back with swap on the 3rd issue
    load_weight(8'd3);
    i0 = cyc + 1;
    for (int k = 0; k < 4 + LAT; k++) begin
      bus.in_valid    = (k < 4);
      bus.in_value    = DW'(k + 1);
      bus.in_accumulate = '0;
      bus.signed_en   = 1'b0; bus.sat_en = 1'b0;
      bus.weight_load = (k == 1); bus.weight_in = 8'd7;
      bus.weight_swap = (k == 2);
      step();
      if (cyc >= i0 + LAT && cyc - i0 - LAT < 4) begin
        chk("thr_valid", bus.out_valid, 1'b1);
        chk("thr_value", bus.out_accumulate, thr_exp[cyc - i0 - LAT]);
      end
    end
    idle_inputs();

    // Saturation then wrap, sticky flag, clear
    load_weight(8'd127);
    issue(8'd127, 32'h7FFF_FFF0, 1'b1, 1'b1);
    wait_result("sat", 32'h7FFF_FFFF);
    chk("sat_ovf", bus.ovf_flag, 1'b1);
    issue(8'd127, 32'h7FFF_FFF0, 1'b1, 1'b0);
    wait_result("wrap", 32'h8000_3EF1);
    step();
    chk("ovf_sticky", bus.ovf_flag, 1'b1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf_flag, 1'b0);

    // Pass-through
    bus.shift = 1'b1; bus.in_value = 8'h5A;
    step();
    chk("pass_load", bus.in_pass, 8'h5A);
    bus.shift = 1'b0; bus.in_value = 8'h11;
    step();
    chk("pass_hold", bus.in_pass, 8'h5A);
    chk("pass_no_valid", bus.out_valid, 1'b0);

    // Reset mid-stream: two issues, reset arrives during the third
    load_weight(8'd9);
    issue(8'd1, 32'd10, 1'b0, 1'b0);
    issue(8'd2, 32'd20, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.in_value = 8'd3;
    RST = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", bus.out_valid, 1'b0);
    chk("rst_async_pass", bus.in_pass, 0);
    step();
    RST = 1'b0;
    idle_inputs();
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      chk("rst_flush_valid", bus.out_valid, 1'b0);
      chk("rst_flush_acc", bus.out_accumulate, 0);
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.in_value    = DW'($urandom);
      bus.shift       = $urandom_range(0, 1);
      bus.weight_in   = DW'($urandom);
      bus.weight_load = ($urandom_range(0, 3) == 0);
      bus.weight_swap = ($urandom_range(0, 3) == 0);
      bus.signed_en   = $urandom_range(0, 1);
      bus.sat_en      = $urandom_range(0, 1);
      bus.ovf_clr     = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: bus.in_accumulate = 32'h7FFF_0000 | AW'($urandom_range(0, 32'hFFFF));
        1: bus.in_accumulate = 32'h8000_0000 | AW'($urandom_range(0, 32'hFFFF));
        default: bus.in_accumulate = AW'($urandom);
      endcase
      step();
    end
    idle_inputs();
    repeat (LAT + 2) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
